// File: rtl/gtp_link_pkg.sv
// gtp_link_pkg: shared state encoding, retry counter width and synchronizer depth for the GTP link sequencer.
package gtp_link_pkg;
  localparam int RETRY_W = 8;
  localparam int SYNC_N = 2;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET      = 3'd1,
    WAIT_LOCK  = 3'd2,
    WAIT_DONE  = 3'd3,
    WAIT_ALIGN = 3'd4,
    UP         = 3'd5
  } st_e;
endpackage

// File: rtl/gtp_link_chan.sv
// gtp_link_chan: one GTP channel bring-up FSM with input synchronizers, timeout retries and link monitoring.
// Error counting is present only when GTP_LINK_STATS_EN is defined; otherwise err_o is tied to 0.
module gtp_link_chan
  import gtp_link_pkg::*;
#(
  parameter int RST_CYC = 16,
  parameter int TO_W    = 20,
  parameter int LOS_CYC = 8,
  parameter int ERR_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic               lock_i,
  input  logic               done_i,
  input  logic               align_i,
  input  logic               los_i,
  input  logic [2:0]         bufst_i,
  output logic               gtp_reset_o,
  output logic               link_up_o,
  output logic [2:0]         state_o,
  output logic [RETRY_W-1:0] retry_o,
  output logic [ERR_W-1:0]   err_o
);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam int TW = TO_W > RW ? TO_W : RW;
  localparam int LW = $clog2(LOS_CYC + 1);
  logic [SYNC_N*5-1:0] sync_q;
  logic                lock, done, align, los, buferr, tmo, inc;
  st_e                 st_q, st_d;
  logic [TW-1:0]       tmr_q;
  logic [LW-1:0]       los_q;
  logic                rst_q, up_q;
  logic [RETRY_W-1:0]  retry_q;
  assign {lock, done, align, los, buferr} = sync_q[SYNC_N*5-1 -: 5];
  // Timer restarts on every state entry, so a wait lasts 2**TO_W-1 cycles before retrying.
  assign tmo = tmr_q == TW'(2**TO_W - 2);
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:       st_d = RESET;
      RESET:      st_d = tmr_q == TW'(RST_CYC - 1) ? WAIT_LOCK : RESET;
      WAIT_LOCK:  st_d = lock ? WAIT_DONE : tmo ? RESET : WAIT_LOCK;
      WAIT_DONE:  st_d = done ? WAIT_ALIGN : tmo ? RESET : WAIT_DONE;
      WAIT_ALIGN: st_d = align ? UP : tmo ? RESET : WAIT_ALIGN;
      UP:         st_d = (!lock || (los && los_q == LW'(LOS_CYC - 1))) ? RESET : UP;
      default:    st_d = IDLE;
    endcase
    if (!en_i) st_d = IDLE;
  end
  assign inc = st_d == RESET && st_q != RESET && st_q != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q  <= '0;
      st_q    <= IDLE;
      tmr_q   <= '0;
      rst_q   <= 1'b1;
      up_q    <= 1'b0;
      los_q   <= '0;
      retry_q <= '0;
    end else begin
      sync_q  <= {sync_q[(SYNC_N-1)*5-1:0], lock_i, done_i, align_i, los_i, bufst_i[2]};
      st_q    <= st_d;
      tmr_q   <= st_d != st_q ? '0 : tmr_q + TW'(1);
      // GTPRESET stays high out of rst until the first pass through RESET releases it.
      rst_q   <= st_d == RESET || (rst_q && st_q == IDLE && st_d == IDLE);
      up_q    <= st_d == UP;
      los_q   <= st_q == UP && los ? los_q + LW'(1) : '0;
      retry_q <= clr_i ? '0 : inc && retry_q != '1 ? retry_q + RETRY_W'(1) : retry_q;
    end
`ifdef GTP_LINK_STATS_EN
  logic [ERR_W-1:0] err_q;
  logic             unused_bs;
  assign unused_bs = ^bufst_i[1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= '0;
    else err_q <= clr_i ? '0 : st_q == UP && (buferr || los) && err_q != '1 ? err_q + ERR_W'(1) : err_q;
  assign err_o = err_q;
`else
  logic unused_bs;
  assign unused_bs = ^{bufst_i[1:0], buferr};
  assign err_o = '0;
`endif
  assign gtp_reset_o = rst_q;
  assign link_up_o   = up_q;
  assign state_o     = st_q;
  assign retry_o     = retry_q;
endmodule

// File: rtl/gtp_link_seq.sv
// gtp_link_seq: NCH independent GTP channel bring-up sequencers (gtp_link_chan).
// Define GTP_LINK_STATS_EN to build the per-channel error counters.
module gtp_link_seq
  import gtp_link_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int RST_CYC = 16,
  parameter int TO_W    = 20,
  parameter int LOS_CYC = 8,
  parameter int ERR_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         chan_en,
  input  logic [NCH-1:0]         plllkdet,
  input  logic [NCH-1:0]         resetdone,
  input  logic [NCH-1:0]         rxbyteisaligned,
  input  logic [NCH-1:0]         rxlossofsync,
  input  logic [3*NCH-1:0]       rxbufstatus,
  input  logic                   clr_cnt,
  output logic [NCH-1:0]         gtp_reset_o,
  output logic [NCH-1:0]         link_up,
  output logic [3*NCH-1:0]       state_o,
  output logic [RETRY_W*NCH-1:0] retry_cnt,
  output logic [ERR_W*NCH-1:0]   err_cnt
);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    gtp_link_chan #(
      .RST_CYC(RST_CYC),
      .TO_W   (TO_W),
      .LOS_CYC(LOS_CYC),
      .ERR_W  (ERR_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en_i       (chan_en[c]),
      .clr_i      (clr_cnt),
      .lock_i     (plllkdet[c]),
      .done_i     (resetdone[c]),
      .align_i    (rxbyteisaligned[c]),
      .los_i      (rxlossofsync[c]),
      .bufst_i    (rxbufstatus[3*c +: 3]),
      .gtp_reset_o(gtp_reset_o[c]),
      .link_up_o  (link_up[c]),
      .state_o    (state_o[3*c +: 3]),
      .retry_o    (retry_cnt[RETRY_W*c +: RETRY_W]),
      .err_o      (err_cnt[ERR_W*c +: ERR_W])
    );
  end
endmodule

// File: doc/gtp_link_seq.md
GTP_LINK_SEQ -- requirements
Module: gtp_link_seq

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning the number of GTP channels managed (1..8).
REQ-002 SHALL have parameter RST_CYC, default 16, meaning the clk cycles gtp_reset_o is held asserted per attempt.
REQ-003 SHALL have parameter TO_W, default 20, meaning the timeout counter width; a wait times out at 2**TO_W-1 cycles.
REQ-004 SHALL have parameter LOS_CYC, default 8, meaning the consecutive loss-of-sync cycles that drop a link.
REQ-005 SHALL have parameter ERR_W, default 16, meaning the width of each per-channel error counter.
REQ-006 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: chan_en  in  NCH  per-channel enable; plllkdet  in  NCH  PLL lock; resetdone  in  NCH  GTP reset done.
REQ-008 SHALL have ports: rxbyteisaligned  in  NCH  comma alignment; rxlossofsync  in  NCH  loss of sync; rxbufstatus  in  3*NCH  elastic buffer status, where bit 2 flags an error.
REQ-009 SHALL have ports: gtp_reset_o  out  NCH  per-channel GTPRESET; link_up  out  NCH  link ready; state_o  out  3*NCH  FSM state.
REQ-010 SHALL have ports: retry_cnt  out  8*NCH  reset attempts, saturating; err_cnt  out  ERR_W*NCH  errors counted while UP, saturating; clr_cnt  in  1  synchronous counter clear.
REQ-011 SHALL sample all status inputs through a 2-flop synchronizer in clk before use; all latencies below are counted from the synchronized value.

Function
REQ-012 SHALL run one independent FSM per channel with states IDLE=0, RESET=1, WAIT_LOCK=2, WAIT_DONE=3, WAIT_ALIGN=4, UP=5.
REQ-013 SHALL move IDLE->RESET when chan_en=1, and from any state to IDLE within 1 cycle when chan_en=0, deasserting link_up in that cycle.
REQ-014 SHALL assert gtp_reset_o only in RESET, for exactly RST_CYC cycles, then go to WAIT_LOCK.
REQ-015 SHALL go WAIT_LOCK->WAIT_DONE on plllkdet=1, WAIT_DONE->WAIT_ALIGN on resetdone=1, and WAIT_ALIGN->UP on rxbyteisaligned=1.
REQ-016 SHALL clear the timeout counter on every state entry; on timeout in any WAIT_* state it SHALL go to RESET and increment retry_cnt, saturating at 255.
REQ-017 SHALL assert link_up combinationally-free (registered) in exactly the cycles state_o=UP.
REQ-018 SHALL, in UP, increment err_cnt once per cycle in which rxbufstatus bit 2=1 or rxlossofsync=1, saturating at 2**ERR_W-1.
REQ-019 SHALL, in UP, go to RESET (retry_cnt+1) after LOS_CYC consecutive rxlossofsync=1 cycles, or immediately on plllkdet=0.
REQ-020 SHALL give clr_cnt priority over a simultaneous increment: counters read 0 the next cycle.
REQ-021 SHALL never let one channel's state or inputs affect another channel.

Reset
REQ-022 SHALL on rst force every FSM to IDLE, gtp_reset_o to all-ones, link_up to 0, and retry_cnt, err_cnt, synchronizers and timers to 0; rst mid-sequence SHALL abort immediately.
REQ-023 SHALL deassert gtp_reset_o after rst release only through the normal RESET state.

Configuration
REQ-024 SHALL compile err_cnt logic only when GTP_LINK_STATS_EN is defined; without it err_cnt is tied to 0 and REQ-018/020 apply to retry_cnt only, with all FSM behaviour unchanged.

Structure
REQ-025 SHALL place the state encodings, the retry width (8) and the synchronizer depth (2) in shared package gtp_link_pkg.
REQ-026 SHALL implement the per-channel FSM as sub-module gtp_link_chan, instantiated NCH times by generate.

Verification
REQ-027 With NCH=2, RST_CYC=16, and plllkdet, resetdone and aligned rising 5 cycles apart: ch0 reaches UP with gtp_reset_o high exactly 16 cycles and link_up=1; retry_cnt=0.
REQ-028 With TO_W=6 and plllkdet held 0: retry_cnt increments every 16+63 cycles and saturates at 255.
REQ-029 In UP, 3 bufstatus[2] pulses plus 7 LOS cycles: err_cnt=10 and the link stays UP; 8 consecutive LOS cycles give RESET and retry_cnt=1.
REQ-030 With rst asserted in WAIT_ALIGN: the next cycle shows state_o=0, gtp_reset_o=1 and counters 0.
REQ-031 chan_en[1]=0 while ch0 cycles: ch1 stays IDLE with no counter changes; clr_cnt coincident with an error leaves err_cnt=0.
REQ-032 Build without GTP_LINK_STATS_EN: err_cnt=0 under REQ-029 stimulus, and the FSM trace is identical.
